// File: rtl/mux_load_counter_pkg.sv
// Shared definitions for the mux_load_counter slice: FSM state encoding
// and the channel-slice helper used by the selector.
package mux_load_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10,
      DONE = 2'b11
   } cntState_e;

   // Bit offset of load channel k inside the packed din bus.
   function automatic int chanBase(int k, int width);
      return k * width;
   endfunction

endpackage

// File: rtl/mux_load_counter_if.sv
// Bus interface for mux_load_counter: control/load inputs driven by the
// master, registered count/flag/state returned by the slave.
interface mux_load_counter_if #(
   parameter int WIDTH = 5,
   parameter int NCH   = 4
);
   localparam int SELW = $clog2(NCH);

   logic                 enable;
   logic                 load;
   logic [SELW-1:0]      sel;
   logic [NCH*WIDTH-1:0] din;
   logic                 up;
   logic [WIDTH-1:0]     limit;
   logic [WIDTH-1:0]     out;
   logic                 tc;
   logic [1:0]           state;

   modport master (
      output enable, load, sel, din, up, limit,
      input  out, tc, state
   );

   modport slave (
      input  enable, load, sel, din, up, limit,
      output out, tc, state
   );
endinterface

// File: rtl/mux_load_counter_mux_nch.sv
// mux_nch: combinational NCH:1 channel selector; a select value with no
// matching channel falls back to channel 0.
module mux_nch
   import mux_load_counter_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int NCH   = 4,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic [SELW-1:0]      sel_i,
   input  logic [NCH*WIDTH-1:0] din_i,
   output logic [WIDTH-1:0]     dout_o
);

   // Channel 0 is the default; any in-range select overrides it.
   always_comb begin
      dout_o = din_i[WIDTH-1:0];
      for (int k = 1; k < NCH; k++) begin
         if (sel_i == SELW'(k)) begin
            dout_o = din_i[chanBase(k, WIDTH) +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/mux_load_counter.sv
// mux_load_counter: loadable up/down counter wrapping modulo (limit+1),
// load value picked from NCH channels, with a 4-state run FSM.
// Optional macro CNT_SAT_EN: saturate at the terminal value in DONE
// instead of wrapping.
module mux_load_counter
   import mux_load_counter_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int NCH   = 4
) (
   input logic               clk,
   input logic               rst,
   mux_load_counter_if.slave bus
);

   localparam int SELW = $clog2(NCH);

   logic [WIDTH-1:0] loadValue;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   cntState_e        state_q, state_d;
   logic             terminal;

   mux_nch #(
      .WIDTH (WIDTH),
      .NCH   (NCH),
      .SELW  (SELW)
   ) uMux (
      .sel_i  (bus.sel),
      .din_i  (bus.din),
      .dout_o (loadValue)
   );

   // Next count, flag and state: load beats enable beats idle.
   always_comb begin
      count_d  = count_q;
      tc_d     = 1'b0;
      state_d  = state_q;
      terminal = bus.up ? (count_q == bus.limit) : (count_q == '0);

      if (bus.load) begin
         count_d = loadValue;
         state_d = bus.enable ? RUN : HOLD;
`ifdef CNT_SAT_EN
      end else if (state_q == DONE) begin
         tc_d = 1'b1;
`endif
      end else if (bus.enable) begin
         state_d = RUN;
         if (terminal) begin
            tc_d = 1'b1;
`ifdef CNT_SAT_EN
            state_d = DONE;
`else
            count_d = bus.up ? '0 : bus.limit;
`endif
         end else begin
            count_d = bus.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
         end
      end else if (state_q == RUN) begin
         state_d = HOLD;
      end
   end

   // Count, flag and FSM registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         state_q <= IDLE;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         state_q <= state_d;
      end
   end

   assign bus.out   = count_q;
   assign bus.tc    = tc_q;
   assign bus.state = state_q;

endmodule
